// File: rtl/hdu_pkg.sv
// Shared types, pipeline-control encodings and the saturating-counter helper
// for the hazard/forwarding controller.
package hdu_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    S_RUN,
    S_HOLD
  } hdu_state_e;

  typedef struct packed {
    logic pc_wren;
    logic ifid_wren;
    logic idex_wren;
    logic exmem_wren;
    logic memwb_wren;
    logic ifid_clear;
    logic idex_clear;
    logic exmem_clear;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = 8'b11111_000;
  localparam pipe_ctrl_t CTRL_STALL  = 8'b00111_010;
  localparam pipe_ctrl_t CTRL_FLUSH  = 8'b11111_111;
  localparam pipe_ctrl_t CTRL_FREEZE = 8'b00000_000;
  localparam pipe_ctrl_t CTRL_RESET  = 8'b01111_111;

  localparam int unsigned MAX_CNT_W = 32;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input int unsigned        width);
    logic [MAX_CNT_W:0] ones;
    ones = ({{MAX_CNT_W{1'b0}}, 1'b1} << width) - {{MAX_CNT_W{1'b0}}, 1'b1};
    return (val == ones[MAX_CNT_W-1:0]) ? val : val + {{(MAX_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hdu_fwd_sel.sv
// Bypass select for one EX-stage operand; the younger EXMEM result wins over MEMWB.
module hdu_fwd_sel
  import hdu_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_rdwren_i,
  input  logic              exmem_is_load_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_rdwren_i,
  output fwd_sel_e          sel_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_rdwren_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit = memwb_rdwren_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  // Load data is not ready in EXMEM, so that case falls through to MEMWB.
  always_comb begin
    sel_o = FWD_RF;
    if (exmem_hit && !exmem_is_load_i) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hdu_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: stall/flush/freeze
// control, load-use hold FSM, EX operand bypass selects and perf counters.
module hdu_fwd_ctrl
  import hdu_pkg::*;
#(
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned LOAD_LAT  = 2,
  parameter bit          RF_WFIRST = 1'b1,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sram_stall,
  input  logic              i_exmem_pcsel,
  input  logic              i_exmem_is_br,
  input  logic              i_exmem_is_uncbr,
  input  logic [REG_AW-1:0] i_ifid_rs1,
  input  logic [REG_AW-1:0] i_ifid_rs2,
  input  logic              i_ifid_rs1_used,
  input  logic              i_ifid_rs2_used,
  input  logic [REG_AW-1:0] i_idex_rs1,
  input  logic [REG_AW-1:0] i_idex_rs2,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_idex_rdwren,
  input  logic              i_exmem_rdwren,
  input  logic              i_memwb_rdwren,
  input  logic              i_idex_is_load,
  input  logic              i_exmem_is_load,
  input  logic              i_cnt_clr,
  output logic              o_pc_wren,
  output logic              o_ifid_wren,
  output logic              o_idex_wren,
  output logic              o_exmem_wren,
  output logic              o_memwb_wren,
  output logic              o_ifid_clear,
  output logic              o_idex_clear,
  output logic              o_exmem_clear,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_sram_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  function automatic logic hit(input logic              used,
                               input logic              wren,
                               input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rd);
    return used && wren && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
  endfunction

  hdu_state_e       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] sram_cnt_q, sram_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  pipe_ctrl_t       ctrl;
  fwd_sel_e         fwd_a, fwd_b;
  logic             flush, raw_hit, idex_hit, exmem_hit, memwb_hit, load_use;
  logic             stall, freeze_act, flush_act;

  assign flush = i_exmem_pcsel && (i_exmem_is_br || i_exmem_is_uncbr);

  always_comb begin
    idex_hit  = hit(i_ifid_rs1_used, i_idex_rdwren, i_ifid_rs1, i_idex_rd) ||
                hit(i_ifid_rs2_used, i_idex_rdwren, i_ifid_rs2, i_idex_rd);
    exmem_hit = hit(i_ifid_rs1_used, i_exmem_rdwren, i_ifid_rs1, i_exmem_rd) ||
                hit(i_ifid_rs2_used, i_exmem_rdwren, i_ifid_rs2, i_exmem_rd);
    memwb_hit = hit(i_ifid_rs1_used, i_memwb_rdwren, i_ifid_rs1, i_memwb_rd) ||
                hit(i_ifid_rs2_used, i_memwb_rdwren, i_ifid_rs2, i_memwb_rd);
    raw_hit   = idex_hit || exmem_hit || (!RF_WFIRST && memwb_hit);
    load_use  = (i_idex_is_load && idex_hit) ||
                ((LOAD_LAT >= 2) && i_exmem_is_load && exmem_hit);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl       = CTRL_RUN;
    stall      = 1'b0;
    freeze_act = 1'b0;
    flush_act  = 1'b0;
    if (!i_reset) begin
      ctrl    = CTRL_RESET;
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (i_sram_stall) begin
      ctrl       = CTRL_FREEZE;
      freeze_act = 1'b1;
    end else if (flush) begin
      ctrl      = CTRL_FLUSH;
      flush_act = 1'b1;
      state_d   = S_RUN;
      cnt_d     = '0;
    end else if (!FWD_EN) begin
      stall = raw_hit;
    end else if (state_q == S_HOLD) begin
      // Remaining bubbles are counted out without re-checking the hazard.
      stall = 1'b1;
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        state_d = S_RUN;
      end
    end else if (load_use) begin
      stall = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = S_HOLD;
        cnt_d   = 2'(LOAD_LAT - 1);
      end
    end
    if (stall) begin
      ctrl = CTRL_STALL;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    sram_cnt_d  = sram_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      sram_cnt_d  = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall)      stall_cnt_d = inc(stall_cnt_q);
      if (freeze_act) sram_cnt_d  = inc(sram_cnt_q);
      if (flush_act)  flush_cnt_d = inc(flush_cnt_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      sram_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sram_cnt_q  <= sram_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  hdu_fwd_sel #(
    .REG_AW(REG_AW)
  ) u_fwd_a (
    .rs_i           (i_idex_rs1),
    .exmem_rd_i     (i_exmem_rd),
    .exmem_rdwren_i (i_exmem_rdwren),
    .exmem_is_load_i(i_exmem_is_load),
    .memwb_rd_i     (i_memwb_rd),
    .memwb_rdwren_i (i_memwb_rdwren),
    .sel_o          (fwd_a)
  );

  hdu_fwd_sel #(
    .REG_AW(REG_AW)
  ) u_fwd_b (
    .rs_i           (i_idex_rs2),
    .exmem_rd_i     (i_exmem_rd),
    .exmem_rdwren_i (i_exmem_rdwren),
    .exmem_is_load_i(i_exmem_is_load),
    .memwb_rd_i     (i_memwb_rd),
    .memwb_rdwren_i (i_memwb_rdwren),
    .sel_o          (fwd_b)
  );

  assign o_fwd_a_sel   = (FWD_EN && i_reset) ? fwd_a : FWD_RF;
  assign o_fwd_b_sel   = (FWD_EN && i_reset) ? fwd_b : FWD_RF;
  assign o_pc_wren     = ctrl.pc_wren;
  assign o_ifid_wren   = ctrl.ifid_wren;
  assign o_idex_wren   = ctrl.idex_wren;
  assign o_exmem_wren  = ctrl.exmem_wren;
  assign o_memwb_wren  = ctrl.memwb_wren;
  assign o_ifid_clear  = ctrl.ifid_clear;
  assign o_idex_clear  = ctrl.idex_clear;
  assign o_exmem_clear = ctrl.exmem_clear;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_sram_cnt    = sram_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;

endmodule
